// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one operand bit per clock.
// Start/busy/done handshake; the result register only updates on the done edge.

module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  // A digit of 5..9 would reach 10..18 after doubling; +3 makes it carry correctly.
  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

module bcd_convert_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      operand, operand_nxt;
  logic [4*DIGITS-1:0]   scratch, adjusted, scratch_nxt;
  logic [CW-1:0]         count;
  logic                  last;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit    (scratch[4*i +: 4]),
      .adjusted (adjusted[4*i +: 4])
    );
  end

  assign {scratch_nxt, operand_nxt} = {adjusted, operand} << 1;
  assign last = (state == SHIFT) && (count == CW'(WIDTH-1));
  assign busy = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand <= '0;
      scratch <= '0;
      count   <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == SHIFT) begin
        operand <= operand_nxt;
        scratch <= scratch_nxt;
        count   <= count + CW'(1);
        // Final iteration goes straight to the output so done lines up with the last shift.
        if (last) begin
          bcd  <= scratch_nxt;
          done <= 1'b1;
        end
      end else if (start) begin
        operand <= bin;
        scratch <= '0;
        count   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Scoreboard bench for bcd_convert_seq at WIDTH=8/DIGITS=3 and WIDTH=16/DIGITS=5.
module tb_bcd_convert_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic [15:0] bin16 = '0;
  logic        busy8, done8, busy16, done16;
  logic [11:0] bcd8;
  logic [19:0] bcd16;

  int checks = 0;
  int errors = 0;
  logic [11:0] q8[$];
  logic [19:0] q16[$];

  always #5 clk = ~clk;

  bcd_convert_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8));

  bcd_convert_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16));

  // Reference: decimal digits by repeated division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (((w == 8) ? busy8 : busy16) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic conv(input int w, input int unsigned v);
    logic [19:0] e;
    e = ref_bcd(v);
    wait_idle(w);
    if (w == 8) begin
      start8 = 1'b1; bin8 = v[7:0]; q8.push_back(e[11:0]);
      @(negedge clk);
      start8 = 1'b0; bin8 = 8'($urandom);
    end else begin
      start16 = 1'b1; bin16 = v[15:0]; q16.push_back(e);
      @(negedge clk);
      start16 = 1'b0; bin16 = 16'($urandom);
    end
  endtask

  // Monitors: pop on done, check result, busy-cycle count, and bcd stability.
  int bc8 = 0, bc16 = 0;
  logic [11:0] prev8 = '0;
  logic [19:0] prev16 = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bc8 = 0; prev8 = bcd8;
    end else begin
      if (busy8) bc8++;
      if (done8) begin
        chk("busy8_with_done", 32'(busy8), 32'd0);
        if (q8.size() == 0) chk("spurious_done8", 32'd1, 32'd0);
        else chk("bcd8", 32'(bcd8), 32'(q8.pop_front()));
        chk("latency8", 32'(bc8), 32'd8);
        bc8 = 0;
      end else begin
        chk("bcd8_hold", 32'(bcd8), 32'(prev8));
      end
      prev8 = bcd8;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bc16 = 0; prev16 = bcd16;
    end else begin
      if (busy16) bc16++;
      if (done16) begin
        chk("busy16_with_done", 32'(busy16), 32'd0);
        if (q16.size() == 0) chk("spurious_done16", 32'd1, 32'd0);
        else chk("bcd16", 32'(bcd16), 32'(q16.pop_front()));
        chk("latency16", 32'(bc16), 32'd16);
        bc16 = 0;
      end else begin
        chk("bcd16_hold", 32'(bcd16), 32'(prev16));
      end
      prev16 = bcd16;
    end
  end

  initial begin
    int n, cyc;
    #3;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_bcd8", 32'(bcd8), 32'd0);
    chk("rst_bcd16", 32'(bcd16), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    conv(8, 0); conv(8, 255); conv(8, 99); conv(8, 100);
    conv(16, 65535); conv(16, 10000); conv(16, 0); conv(16, 9999);

    for (int v = 0; v < 256; v++) conv(8, v);

    // start with a new operand mid-conversion must be ignored
    conv(8, 200);
    @(negedge clk); @(negedge clk);
    start8 = 1'b1; bin8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle(8);
    repeat (12) @(negedge clk);

    // start held continuously: back-to-back conversions
    wait_idle(8);
    start8 = 1'b1; bin8 = 8'd42; q8.push_back(12'h042);
    n = 0; cyc = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        n++;
        if (n == 3) start8 = 1'b0;
        else q8.push_back(12'h042);
      end
    end
    start8 = 1'b0;
    if (n < 3) chk("held_start_timeout", 32'(n), 32'd3);
    wait_idle(8);

    // reset mid-conversion aborts with no done
    conv(8, 123);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q8.delete(); q16.delete();
    #1;
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_bcd8", 32'(bcd8), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    conv(8, 45);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      conv(8, $urandom_range(0, 255));
    end
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      conv(16, $urandom_range(0, 65535));
    end

    wait_idle(8); wait_idle(16);
    repeat (20) @(negedge clk);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    chk("q16_empty", 32'(q16.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
